lfsr_checker: RTL and testbench
===============================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter TAPS, default 8'hB8, Fibonacci feedback mask (x^8+x^6+x^5+x^4+1).
REQ-002 SHALL have parameter LOCK_COUNT, default 4, consecutive matches required to declare lock (range 1..15).
REQ-003 SHALL have parameter LOSS_COUNT, default 3, consecutive mismatches that declare loss of sync (range 1..15).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port data_in  input  8  byte from the upstream lfsr data output.
REQ-007 SHALL have port data_valid  input  1  data_in is a new sample this cycle.
REQ-008 SHALL have port clear  input  1  synchronous clear of counters and error flags (state kept).
REQ-009 SHALL have port locked  output  1  high while in CHECK state.
REQ-010 SHALL have port error  output  1  one-cycle pulse on each mismatch while locked.
REQ-011 SHALL have port err_count  output  16  saturating mismatch count.
REQ-012 SHALL have port stuck_zero  output  1  sticky flag: data_in == 0 seen with data_valid.
REQ-013 SHALL have port state  output  2  current FSM state encoding.

Function
REQ-014 Prediction SHALL be next(x) = {x[6:0], ^(x & TAPS)}; checker holds 8-bit predictor pred.
REQ-015 FSM SHALL have states IDLE=0, ACQUIRE=1, CHECK=2, LOST=3; cycles without data_valid change nothing except clear.
REQ-016 IDLE: on data_valid, pred <= next(data_in), match counter <= 0, go ACQUIRE.
REQ-017 ACQUIRE: on data_valid with data_in == pred, match counter +1, pred <= next(data_in); when counter reaches LOCK_COUNT go CHECK.
REQ-018 ACQUIRE: on data_valid with mismatch, reseed pred <= next(data_in), counter <= 0, stay ACQUIRE; no error pulse, err_count unchanged.
REQ-019 CHECK: on match, miss counter <= 0, pred <= next(pred).
REQ-020 CHECK: on mismatch, error pulses next cycle, err_count +1 (saturate at 16'hFFFF), miss counter +1, pred <= next(pred) (free-running, not reseeded).
REQ-021 CHECK: when miss counter reaches LOSS_COUNT, go LOST in the same update.
REQ-022 LOST: on next data_valid, pred <= next(data_in), counter <= 0, go ACQUIRE; no error pulse.
REQ-023 Outputs SHALL be registered; locked/error/state reflect the sample one cycle after data_valid.
REQ-024 data_valid with data_in == 0 SHALL set stuck_zero in any state and is treated as a mismatch per the state rules (next(0)=0 never locks).
REQ-025 clear coincident with a mismatch: clear wins; err_count = 0, error = 0, stuck_zero = 0; FSM and predictor still update normally.

Reset
REQ-026 reset_n low SHALL immediately force state=IDLE, pred=0, counters=0, locked=0, error=0, err_count=0, stuck_zero=0.
REQ-027 Reset asserted mid-sequence SHALL discard lock; after release the checker requires full reacquisition (LOCK_COUNT matches).

Structure
REQ-028 Shared package lfsr_pkg SHALL hold the default TAPS, default seed 8'h8A, the state encoding and a next-value function shared with the lfsr generator.
REQ-029 The FSM and counters SHALL be in lfsr_checker; the predictor step SHALL be a sub-module lfsr_step (combinational next(x)) reused by the generator.

Verification
REQ-030 Feed 8'h8A,8'h14,8'h29,... one per cycle with data_valid -> locked rises after 5th sample (1 seed + 4 matches), err_count=0.
REQ-031 While locked, replace one byte with 8'hFF -> error high exactly one cycle, err_count=1, locked stays 1.
REQ-032 While locked, corrupt 3 consecutive samples -> err_count=3, state=LOST, locked=0; clean stream resumes -> relock after 5 samples.
REQ-033 Send data_in=8'h00 with data_valid -> stuck_zero=1 and stays 1 until clear or reset; never locks on zero stream.
REQ-034 Pulse reset_n low between clock edges while locked -> locked, err_count, state clear asynchronously; relock needs 5 valid samples.
REQ-035 Force 65540 mismatches with periodic reseed -> err_count saturates at 16'hFFFF; clear with a coincident mismatch -> err_count=0, error=0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator/checker pair: default polynomial,
// default seed, checker state encoding and the Fibonacci next-value function.
package lfsr_pkg;

    localparam logic [7:0] DEFAULT_TAPS = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'h8A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_CHECK   = 2'd2,
        ST_LOST    = 2'd3
    } state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] x, input logic [7:0] taps);
        return {x[6:0], ^(x & taps)};
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single step of the Fibonacci LFSR; shared by generator and checker.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter logic [7:0] TAPS = DEFAULT_TAPS
) (
    input  logic [7:0] x,
    output logic [7:0] y
);

    assign y = lfsr_next(x, TAPS);

endmodule

// File: rtl/lfsr_checker.sv
// Tracks an upstream LFSR byte stream: acquires lock after LOCK_COUNT good
// predictions, counts mismatches while locked and drops lock after LOSS_COUNT misses.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter logic [7:0]  TAPS       = DEFAULT_TAPS,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    input  logic        clear,
    output logic        locked,
    output logic        error,
    output logic [15:0] err_count,
    output logic        stuck_zero,
    output logic [1:0]  state
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

    state_t      state_q, state_d;
    logic [7:0]  pred_q, pred_d;
    logic [3:0]  match_q, match_d;
    logic [3:0]  miss_q, miss_d;
    logic        locked_q, locked_d;
    logic        error_q, error_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        stuck_q, stuck_d;

    logic [7:0]  next_data;
    logic [7:0]  next_pred;
    logic        sample_ok;
    logic [3:0]  match_inc;
    logic [3:0]  miss_inc;

    lfsr_step #(.TAPS(TAPS)) u_step_data (.x(data_in), .y(next_data));
    lfsr_step #(.TAPS(TAPS)) u_step_pred (.x(pred_q),  .y(next_pred));

    // A zero byte is never a valid match: next(0)=0 would otherwise lock on a dead stream.
    assign sample_ok = (data_in == pred_q) && (data_in != '0);
    assign match_inc = match_q + 4'd1;
    assign miss_inc  = miss_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        pred_d    = pred_q;
        match_d   = match_q;
        miss_d    = miss_q;
        err_cnt_d = err_cnt_q;
        stuck_d   = stuck_q;
        error_d   = 1'b0;

        if (data_valid) begin
            if (data_in == '0) begin
                stuck_d = 1'b1;
            end
            case (state_q)
                ST_IDLE, ST_LOST: begin
                    pred_d  = next_data;
                    match_d = '0;
                    state_d = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    pred_d = next_data;
                    if (sample_ok) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_N) begin
                            state_d = ST_CHECK;
                            miss_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                ST_CHECK: begin
                    // Predictor free-runs while locked so a burst of bad bytes cannot reseed it.
                    pred_d = next_pred;
                    if (sample_ok) begin
                        miss_d = '0;
                    end else begin
                        error_d = 1'b1;
                        miss_d  = miss_inc;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                        if (miss_inc == LOSS_N) begin
                            state_d = ST_LOST;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (clear) begin
            err_cnt_d = '0;
            error_d   = 1'b0;
            stuck_d   = 1'b0;
        end

        locked_d = (state_d == ST_CHECK);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pred_q    <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            locked_q  <= 1'b0;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
            stuck_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pred_q    <= pred_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            locked_q  <= locked_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
            stuck_q   <= stuck_d;
        end
    end

    assign locked     = locked_q;
    assign error      = error_q;
    assign err_count  = err_cnt_q;
    assign stuck_zero = stuck_q;
    assign state      = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a default instance for stream behaviour and a
// LOSS_COUNT=15 instance that can stay locked long enough to saturate err_count.
module tb_lfsr_checker;

    logic        clk;
    logic        reset_n;
    logic [7:0]  din0, din1;
    logic        dv0, dv1, clr0, clr1;
    logic        lk0, lk1, er0, er1, sz0, sz1;
    logic [15:0] ec0, ec1;
    logic [1:0]  st0, st1;

    lfsr_checker #(.TAPS(8'hB8), .LOCK_COUNT(4), .LOSS_COUNT(3)) u_dut (
        .clk(clk), .reset_n(reset_n), .data_in(din0), .data_valid(dv0), .clear(clr0),
        .locked(lk0), .error(er0), .err_count(ec0), .stuck_zero(sz0), .state(st0)
    );

    lfsr_checker #(.TAPS(8'hB8), .LOCK_COUNT(4), .LOSS_COUNT(15)) u_sat (
        .clk(clk), .reset_n(reset_n), .data_in(din1), .data_valid(dv1), .clear(clr1),
        .locked(lk1), .error(er1), .err_count(ec1), .stuck_zero(sz1), .state(st1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         dut;
        int         idx;
        bit         locked;
        bit         error;
        int         errc;
        bit         sz;
        int         state;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_samples = 0;

    // Reference model: spec-level view of each checker (0=IDLE 1=ACQUIRE 2=CHECK 3=LOST)
    int         m_state[2];
    logic [7:0] m_pred[2];
    int         m_run[2];
    int         m_miss[2];
    int         m_err[2];
    bit         m_sz[2];
    bit         m_pulse[2];
    int         lock_n[2] = '{4, 4};
    int         loss_n[2] = '{3, 15};

    function automatic logic [7:0] ref_next(input logic [7:0] x);
        return {x[6:0], ($countones(x & 8'hB8) % 2) == 1};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_state[d] = 0; m_pred[d] = 8'h00; m_run[d] = 0; m_miss[d] = 0;
            m_err[d] = 0; m_sz[d] = 0; m_pulse[d] = 0;
        end
    endtask

    task automatic model_step(input int d, input bit v, input logic [7:0] b, input bit c);
        bit good;
        m_pulse[d] = 0;
        if (v) begin
            good = (b == m_pred[d]) && (b != 8'h00);
            if (b == 8'h00) m_sz[d] = 1;
            if (m_state[d] == 2) begin
                m_pred[d] = ref_next(m_pred[d]);
                if (good) m_miss[d] = 0;
                else begin
                    m_pulse[d] = 1;
                    m_err[d] = (m_err[d] >= 65535) ? 65535 : m_err[d] + 1;
                    m_miss[d]++;
                    if (m_miss[d] == loss_n[d]) m_state[d] = 3;
                end
            end else begin
                // IDLE, LOST and ACQUIRE all reseed from the incoming byte
                if (m_state[d] == 1 && good) m_run[d]++;
                else m_run[d] = 0;
                m_pred[d] = ref_next(b);
                if (m_state[d] == 1 && m_run[d] == lock_n[d]) begin
                    m_state[d] = 2;
                    m_miss[d] = 0;
                end else m_state[d] = 1;
            end
        end
        if (c) begin
            m_err[d] = 0; m_pulse[d] = 0; m_sz[d] = 0;
        end
    endtask

    task automatic chk(input string nm, input int d, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s dut%0d sample %0d: got %0h expected %0h", nm, d, idx, act, exp);
        end
    endtask

    task automatic drive(input int d, input bit v, input logic [7:0] b, input bit c);
        exp_t e;
        @(negedge clk);
        dv0  = (d == 0) && v;  din0 = (d == 0) ? b : 8'h00;  clr0 = (d == 0) && c;
        dv1  = (d == 1) && v;  din1 = (d == 1) ? b : 8'h00;  clr1 = (d == 1) && c;
        model_step(d, v, b, c);
        model_step(1 - d, 1'b0, 8'h00, 1'b0);
        e.dut = d; e.idx = n_samples++;
        e.locked = (m_state[d] == 2); e.error = m_pulse[d]; e.errc = m_err[d];
        e.sz = m_sz[d]; e.state = m_state[d];
        sb.push_back(e);
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic pulse_reset();
        @(negedge clk);
        dv0 = 0; dv1 = 0; clr0 = 0; clr1 = 0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_state", 0, -1, int'(st0), 0);
        chk("rst_locked", 0, -1, int'(lk0), 0);
        chk("rst_errcnt", 0, -1, int'(ec0), 0);
        chk("rst_flags", 0, -1, int'({er0, sz0}), 0);
        chk("rst_sat", 1, -1, int'({lk1, er1, sz1, st1, ec1}), 0);
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            if (mon_e.dut == 0) begin
                chk("locked", 0, mon_e.idx, int'(lk0), int'(mon_e.locked));
                chk("error", 0, mon_e.idx, int'(er0), int'(mon_e.error));
                chk("err_count", 0, mon_e.idx, int'(ec0), mon_e.errc);
                chk("stuck_zero", 0, mon_e.idx, int'(sz0), int'(mon_e.sz));
                chk("state", 0, mon_e.idx, int'(st0), mon_e.state);
            end else begin
                chk("locked", 1, mon_e.idx, int'(lk1), int'(mon_e.locked));
                chk("error", 1, mon_e.idx, int'(er1), int'(mon_e.error));
                chk("err_count", 1, mon_e.idx, int'(ec1), mon_e.errc);
                chk("stuck_zero", 1, mon_e.idx, int'(sz1), int'(mon_e.sz));
                chk("state", 1, mon_e.idx, int'(st1), mon_e.state);
            end
        end
    end

    logic [7:0] g;

    task automatic clean(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            drive(d, 1'b1, g, 1'b0);
            g = ref_next(g);
        end
    endtask

    task automatic corrupt(input int d, input int n, input logic [7:0] mask);
        for (int i = 0; i < n; i++) begin
            drive(d, 1'b1, g ^ mask, 1'b0);
            g = ref_next(g);
        end
    endtask

    initial begin
        int total;
        int r;
        reset_n = 1'b1;
        din0 = 0; din1 = 0; dv0 = 0; dv1 = 0; clr0 = 0; clr1 = 0;
        model_reset();
        #2 reset_n = 1'b0;
        #10 reset_n = 1'b1;
        chk("init_state", 0, -1, int'(st0), 0);

        // Lock on the reference stream, then single-byte error, then loss and relock
        pulse_reset();
        g = 8'h8A;
        clean(0, 5);
        drive(0, 1'b0, 8'h00, 1'b0);
        clean(0, 3);
        drive(0, 1'b1, 8'hFF, 1'b0); g = ref_next(g);
        drive(0, 1'b0, 8'h00, 1'b0);
        clean(0, 3);
        corrupt(0, 3, 8'h5A);
        drive(0, 1'b0, 8'h00, 1'b0);
        clean(0, 5);
        drive(0, 1'b0, 8'h00, 1'b0);

        // Zero stream: sticky flag, never locks, cleared by clear
        pulse_reset();
        for (int i = 0; i < 8; i++) drive(0, 1'b1, 8'h00, 1'b0);
        drive(0, 1'b0, 8'h00, 1'b0);
        g = 8'h3C;
        clean(0, 2);
        drive(0, 1'b0, 8'h00, 1'b1);
        drive(0, 1'b0, 8'h00, 1'b0);

        // Reset while locked discards lock; full reacquisition required
        g = 8'h8A;
        clean(0, 5);
        corrupt(0, 1, 8'h0F);
        pulse_reset();
        clean(0, 4);
        clean(0, 1);
        drive(0, 1'b0, 8'h00, 1'b0);

        // Randomised mix of clean, corrupt, zero, idle, clear and stream jumps
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 19);
            if (r < 11) clean(0, 1);
            else if (r < 13) corrupt(0, 1, 8'($urandom_range(1, 255)));
            else if (r == 13) drive(0, 1'b1, 8'h00, 1'b0);
            else if (r < 16) drive(0, 1'b0, 8'($urandom), 1'b0);
            else if (r == 16) begin
                drive(0, 1'($urandom), g, 1'b1); g = ref_next(g);
            end else if (r == 17) g = 8'($urandom_range(1, 255));
            else clean(0, 2);
        end

        // Saturation on the long-loss instance: 14 misses then one match keeps it locked
        pulse_reset();
        g = 8'h8A;
        clean(1, 5);
        total = 0;
        while (total < 65540) begin
            corrupt(1, 14, 8'h81);
            total += 14;
            clean(1, 1);
        end
        drive(1, 1'b1, g ^ 8'h42, 1'b1); g = ref_next(g);
        drive(1, 1'b0, 8'h00, 1'b0);
        corrupt(1, 1, 8'h18);
        drive(1, 1'b0, 8'h00, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", 0, -1, sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
